// File: rtl/pkg_ram.sv
// Shared RAM command encodings used by the arbiter and its requesters.
package pkg_ram;

  localparam int RAM_ADDRW = 16;

  localparam logic [1:0] RAM_NOP   = 2'd0;
  localparam logic [1:0] RAM_LOAD  = 2'd1;
  localparam logic [1:0] RAM_STORE = 2'd2;

  localparam logic [1:0] RAM_BYTE  = 2'd0;
  localparam logic [1:0] RAM_HALF  = 2'd1;
  localparam logic [1:0] RAM_WORD  = 2'd2;
  localparam logic [1:0] RAM_DWORD = 2'd3;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus between the two requesters, the arbiter and the RAM.
//   boot_done            : port 1 may be granted once boot is over
//   req/op/type/addr/wdata: per-port request (0 = loader, 1 = CPU)
//   gnt                  : combinational accept, per port
//   rvalid/rdata         : per-port load return
//   ram_*                : registered RAM command, ram_rdata returned by the RAM
// Modport slave is the arbiter view; master is the requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDRW = pkg_ram::RAM_ADDRW,
  parameter int DATAW = 64
);
  logic             boot_done;
  logic             req0, req1;
  logic [1:0]       op0, op1;
  logic [1:0]       type0, type1;
  logic [ADDRW-1:0] addr0, addr1;
  logic [DATAW-1:0] wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             rvalid0, rvalid1;
  logic [DATAW-1:0] rdata0, rdata1;
  logic [1:0]       ram_op, ram_type;
  logic [ADDRW-1:0] ram_addr;
  logic [DATAW-1:0] ram_wdata;
  logic [DATAW-1:0] ram_rdata;

  modport slave (
    input  boot_done, req0, req1, op0, op1, type0, type1,
           addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_op, ram_type, ram_addr, ram_wdata
  );

  modport master (
    output boot_done, req0, req1, op0, op1, type0, type1,
           addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_op, ram_type, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single RAM with fixed load
// latency LAT (1..4). Port 1 (CPU) is only eligible once boot_done is high.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous, active-low reset
//   bus  : ram_arbiter_if.slave (requests, grants, load returns, RAM command)
module ram_arbiter #(
  parameter int ADDRW = pkg_ram::RAM_ADDRW,
  parameter int DATAW = 64,
  parameter int LAT   = 1
) (
  input logic            clk,
  input logic            rst,
  ram_arbiter_if.slave   bus
);
  import pkg_ram::*;

  logic             elig0, elig1;
  logic             last_gnt;       // 1 = port 1 granted most recently
  logic             cmd_port;       // port owning the command on ram_*
  logic [LAT-1:0]   tag_v;          // in-flight load valid, per latency stage
  logic [LAT-1:0]   tag_p;          // in-flight load owner, per latency stage
  logic [1:0]       sel_op, sel_type;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_wdata;

  assign elig0 = bus.req0 && (bus.op0 != RAM_NOP);
  assign elig1 = bus.req1 && (bus.op1 != RAM_NOP) && bus.boot_done;

  // Grants are combinational; qualifying with rst keeps them low throughout
  // reset rather than only after the first edge.
  assign bus.gnt0 = rst && elig0 && (!elig1 || last_gnt);
  assign bus.gnt1 = rst && elig1 && !bus.gnt0;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sel_op    = bus.op0;
    sel_type  = bus.type0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (bus.gnt1) begin
      sel_op    = bus.op1;
      sel_type  = bus.type1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt      <= 1'b1;
      cmd_port      <= 1'b0;
      bus.ram_op    <= RAM_NOP;
      bus.ram_type  <= RAM_BYTE;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else if (bus.gnt0 || bus.gnt1) begin
      last_gnt      <= bus.gnt1;
      cmd_port      <= bus.gnt1;
      bus.ram_op    <= sel_op;
      bus.ram_type  <= sel_type;
      bus.ram_addr  <= sel_addr;
      bus.ram_wdata <= sel_wdata;
    end else begin
      // Idle cycle: issue a NOP, leave the other command fields untouched.
      bus.ram_op    <= RAM_NOP;
    end
  end

  // Tag pipeline fed from the issued command: stage 0 is loaded at the end of
  // the command cycle, so stage LAT-1 lines up with the RAM's returned data.
  // NOTE: the tag valid bits are reset so a reset mid-load drops every load
  // in flight; the owner bits are reset too only to keep outputs defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v[0] <= (bus.ram_op == RAM_LOAD);
      tag_p[0] <= cmd_port;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  // Only one tag leaves the pipeline per cycle, so the rvalids are exclusive.
  assign bus.rvalid0 = tag_v[LAT-1] && !tag_p[LAT-1];
  assign bus.rvalid1 = tag_v[LAT-1] &&  tag_p[LAT-1];
  assign bus.rdata0  = bus.rvalid0 ? bus.ram_rdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with LAT=2, ADDRW=16, DATAW=64.
module tb_ram_arbiter;
  import pkg_ram::*;

  localparam int ADDRW = 16;
  localparam int DATAW = 64;
  localparam int LAT   = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ram_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  ram_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.op0 = RAM_NOP; bus.type0 = RAM_BYTE;
    bus.addr0 = '0;  bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.op1 = RAM_NOP; bus.type1 = RAM_BYTE;
    bus.addr1 = '0;  bus.wdata1 = '0;
    bus.ram_rdata = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.boot_done = 1'b0;
    idle_inputs();

    // Reset state, with a pending request that must not be granted.
    bus.req0 = 1'b1; bus.op0 = RAM_LOAD;
    tick();
    tick();
    check("rst_gnt0",    64'(bus.gnt0), 64'd0);
    check("rst_gnt1",    64'(bus.gnt1), 64'd0);
    check("rst_rvalid0", 64'(bus.rvalid0), 64'd0);
    check("rst_rvalid1", 64'(bus.rvalid1), 64'd0);
    check("rst_rdata0",  bus.rdata0, 64'd0);
    check("rst_rdata1",  bus.rdata1, 64'd0);
    check("rst_ram_op",  64'(bus.ram_op), 64'(RAM_NOP));
    check("rst_ram_type", 64'(bus.ram_type), 64'(RAM_BYTE));
    check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_ram_wdata", bus.ram_wdata, 64'd0);
    idle_inputs();
    rst = 1'b1;

    // Boot phase: port 0 store wins, port 1 load is blocked.
    bus.req0 = 1'b1; bus.op0 = RAM_STORE; bus.type0 = RAM_BYTE;
    bus.addr0 = 16'h0010; bus.wdata0 = 64'hA5;
    bus.req1 = 1'b1; bus.op1 = RAM_LOAD; bus.addr1 = 16'h0020;
    #1;
    check("boot_gnt0", 64'(bus.gnt0), 64'd1);
    check("boot_gnt1", 64'(bus.gnt1), 64'd0);
    tick();
    bus.req0 = 1'b0; bus.op0 = RAM_NOP;
    #1;
    check("store_ram_op",    64'(bus.ram_op), 64'(RAM_STORE));
    check("store_ram_addr",  64'(bus.ram_addr), 64'h10);
    check("store_ram_wdata", bus.ram_wdata, 64'hA5);
    check("store_ram_type",  64'(bus.ram_type), 64'(RAM_BYTE));
    check("boot_gnt1_held",  64'(bus.gnt1), 64'd0);
    tick();
    check("idle_ram_op",   64'(bus.ram_op), 64'(RAM_NOP));
    check("idle_ram_addr", 64'(bus.ram_addr), 64'h10);
    tick();
    tick();
    check("store_no_rvalid0", 64'(bus.rvalid0), 64'd0);
    check("store_no_rvalid1", 64'(bus.rvalid1), 64'd0);
    idle_inputs();

    // Reset pulse so the pointer starts at port 1 again.
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Round robin with both ports loading every cycle.
    bus.boot_done = 1'b1;
    bus.req0 = 1'b1; bus.op0 = RAM_LOAD; bus.addr0 = 16'h0100;
    bus.req1 = 1'b1; bus.op1 = RAM_LOAD; bus.addr1 = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_gnt0_%0d", k), 64'(bus.gnt0), 64'((k % 2) == 0));
      check($sformatf("rr_gnt1_%0d", k), 64'(bus.gnt1), 64'((k % 2) == 1));
      tick();
      check($sformatf("rr_addr_%0d", k), 64'(bus.ram_addr),
            ((k % 2) == 0) ? 64'h100 : 64'h200);
      check($sformatf("rr_op_%0d", k), 64'(bus.ram_op), 64'(RAM_LOAD));
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();

    // Single port 1 load, LAT=2: rvalid1 in cycle N+3.
    bus.req1 = 1'b1; bus.op1 = RAM_LOAD; bus.addr1 = 16'h0008;
    #1;
    check("lat_gnt1", 64'(bus.gnt1), 64'd1);
    tick();
    bus.req1 = 1'b0; bus.op1 = RAM_NOP;
    check("lat_ram_op",   64'(bus.ram_op), 64'(RAM_LOAD));
    check("lat_ram_addr", 64'(bus.ram_addr), 64'h8);
    tick();
    check("lat_early_rvalid1", 64'(bus.rvalid1), 64'd0);
    tick();
    bus.ram_rdata = 64'h1234;
    #1;
    check("lat_rvalid1", 64'(bus.rvalid1), 64'd1);
    check("lat_rdata1",  bus.rdata1, 64'h1234);
    check("lat_rvalid0", 64'(bus.rvalid0), 64'd0);
    check("lat_rdata0",  bus.rdata0, 64'd0);
    tick();
    bus.ram_rdata = '0;
    check("lat_rvalid1_pulse", 64'(bus.rvalid1), 64'd0);

    // Back-to-back loads, port 0 then port 1.
    bus.req0 = 1'b1; bus.op0 = RAM_LOAD; bus.addr0 = 16'h0030;
    #1;
    check("b2b_gnt0", 64'(bus.gnt0), 64'd1);
    tick();
    bus.req0 = 1'b0; bus.op0 = RAM_NOP;
    bus.req1 = 1'b1; bus.op1 = RAM_LOAD; bus.addr1 = 16'h0040;
    #1;
    check("b2b_gnt1", 64'(bus.gnt1), 64'd1);
    tick();
    bus.req1 = 1'b0; bus.op1 = RAM_NOP;
    tick();
    bus.ram_rdata = 64'hAAAA;
    #1;
    check("b2b_rvalid0", 64'(bus.rvalid0), 64'd1);
    check("b2b_rdata0",  bus.rdata0, 64'hAAAA);
    check("b2b_rvalid1_a", 64'(bus.rvalid1), 64'd0);
    check("b2b_rdata1_a",  bus.rdata1, 64'd0);
    tick();
    bus.ram_rdata = 64'hBBBB;
    #1;
    check("b2b_rvalid1", 64'(bus.rvalid1), 64'd1);
    check("b2b_rdata1",  bus.rdata1, 64'hBBBB);
    check("b2b_rvalid0_b", 64'(bus.rvalid0), 64'd0);
    check("b2b_rdata0_b",  bus.rdata0, 64'd0);
    tick();
    bus.ram_rdata = '0;
    check("b2b_done0", 64'(bus.rvalid0), 64'd0);
    check("b2b_done1", 64'(bus.rvalid1), 64'd0);

    // Port 1 load in flight while boot_done falls.
    bus.req1 = 1'b1; bus.op1 = RAM_LOAD; bus.addr1 = 16'h0050;
    #1;
    check("bd_gnt1", 64'(bus.gnt1), 64'd1);
    tick();
    bus.boot_done = 1'b0;
    #1;
    check("bd_fall_gnt1", 64'(bus.gnt1), 64'd0);
    tick();
    check("bd_fall_gnt1_b", 64'(bus.gnt1), 64'd0);
    tick();
    bus.ram_rdata = 64'h5555;
    #1;
    check("bd_rvalid1", 64'(bus.rvalid1), 64'd1);
    check("bd_rdata1",  bus.rdata1, 64'h5555);
    check("bd_gnt1_c",  64'(bus.gnt1), 64'd0);
    tick();
    idle_inputs();
    bus.boot_done = 1'b1;

    // Reset asserted while a port 0 load is in flight.
    bus.req0 = 1'b1; bus.op0 = RAM_LOAD; bus.addr0 = 16'h0060;
    #1;
    check("rl_gnt0", 64'(bus.gnt0), 64'd1);
    tick();
    idle_inputs();
    rst = 1'b0;
    #1;
    check("rl_ram_op_rst", 64'(bus.ram_op), 64'(RAM_NOP));
    check("rl_rvalid0_rst", 64'(bus.rvalid0), 64'd0);
    tick();
    rst = 1'b1;
    bus.ram_rdata = 64'h7777;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rl_rvalid0_%0d", k), 64'(bus.rvalid0), 64'd0);
      check($sformatf("rl_ram_op_%0d", k), 64'(bus.ram_op), 64'(RAM_NOP));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
